alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer that shares one internally instantiated `ALU_main` (4-bit AND/OR/ADD/SUB with N/Z/C/V flags) between two clients. Each client issues an operation over a valid/ready request channel and collects the registered result and flags over a valid/ready response channel. At most one operation is in flight; the block keeps a wrapping count of completed operations for debug.

---
 rtl/alu_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-client round-robin arbiter and sequencer around one shared
// 4-bit ALU (ALU_main). At most one operation is in flight at a time.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   req_valid_x / req_ready_x     request handshake, client x = 0/1
//   req_a_x, req_b_x, req_op_x    operands and ALU control (00 AND, 01 OR,
//                                 10 A+B, 11 A-B)
//   resp_valid_x / resp_ready_x   response handshake, client x = 0/1
//   resp_result, resp_flags       registered result and {N,Z,C,V}, shared
//   busy                          high whenever the FSM is not idle
//   op_count                      completed-operation counter, wraps at 256
//
// State table
//   S_IDLE | waiting for a request, grant computed combinationally
//   S_EXEC | ALU evaluates latched operands, result captured at cycle end
//   S_RESP | response held for the owner until it is consumed

module ALU_main (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [1:0] op_i,
  output logic [3:0] result_o,
  output logic [3:0] flags_o
);

  logic [4:0] sum;
  logic       carry;
  logic       ovf;

  always_comb begin
    sum      = 5'd0;
    result_o = 4'd0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op_i)
      2'b00: result_o = a_i & b_i;
      2'b01: result_o = a_i | b_i;
      2'b10: begin
        sum      = {1'b0, a_i} + {1'b0, b_i};
        result_o = sum[3:0];
        carry    = sum[4];
        ovf      = (a_i[3] == b_i[3]) && (sum[3] != a_i[3]);
      end
      default: begin
        // A - B as A + ~B + 1; carry out set means no borrow
        sum      = {1'b0, a_i} + {1'b0, ~b_i} + 5'd1;
        result_o = sum[3:0];
        carry    = sum[4];
        ovf      = (a_i[3] != b_i[3]) && (sum[3] != a_i[3]);
      end
    endcase
    flags_o = {result_o[3], (result_o == 4'd0), carry, ovf};
  end

endmodule

module alu_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  input  logic [1:0]       req_op_0,
  input  logic [1:0]       req_op_1,
  output logic             resp_valid_0,
  output logic             resp_valid_1,
  input  logic             resp_ready_0,
  input  logic             resp_ready_1,
  output logic [WIDTH-1:0] resp_result,
  output logic [3:0]       resp_flags,
  output logic             busy,
  output logic [7:0]       op_count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic [7:0]       count_q, count_d;

  logic             grant_0;
  logic             grant_1;
  logic             resp_ready_owner;
  logic [WIDTH-1:0] alu_result;
  logic [3:0]       alu_flags;

  // The ALU only ever sees the latched operands, so request inputs may
  // change freely once accepted.
  ALU_main u_alu (
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (alu_result),
    .flags_o  (alu_flags)
  );

  assign resp_ready_owner = owner_q ? resp_ready_1 : resp_ready_0;

  always_comb begin
    state_d  = state_q;
    prio_d   = prio_q;
    owner_d  = owner_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    result_d = result_q;
    flags_d  = flags_q;
    count_d  = count_q;
    grant_0  = 1'b0;
    grant_1  = 1'b0;
    case (state_q)
      S_IDLE: begin
        // A lone requester always wins; on contention prio_q picks the client.
        grant_0 = req_valid_0 & (~req_valid_1 | ~prio_q);
        grant_1 = req_valid_1 & (~req_valid_0 |  prio_q);
        if (grant_0 | grant_1) begin
          owner_d = grant_1;
          a_d     = grant_1 ? req_a_1  : req_a_0;
          b_d     = grant_1 ? req_b_1  : req_b_0;
          op_d    = grant_1 ? req_op_1 : req_op_0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        result_d = alu_result;
        flags_d  = alu_flags;
        state_d  = S_RESP;
      end
      S_RESP: begin
        if (resp_ready_owner) begin
          prio_d  = ~owner_q;
          count_d = count_q + 8'd1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      prio_q   <= 1'b0;
      owner_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'd0;
      result_q <= '0;
      flags_q  <= 4'd0;
      count_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      prio_q   <= prio_d;
      owner_q  <= owner_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      count_q  <= count_d;
    end
  end

  // Ready is masked while reset is held so no client sees a false accept.
  assign req_ready_0  = grant_0 & ~rst;
  assign req_ready_1  = grant_1 & ~rst;
  assign resp_valid_0 = (state_q == S_RESP) & ~owner_q;
  assign resp_valid_1 = (state_q == S_RESP) &  owner_q;
  assign resp_result  = result_q;
  assign resp_flags   = flags_q;
  assign busy         = (state_q != S_IDLE);
  assign op_count     = count_q;

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

  logic       clk;
  logic       rst;
  logic       v [2];
  logic       rr[2];
  logic [3:0] a [2];
  logic [3:0] b [2];
  logic [1:0] op[2];

  logic       req_ready_0, req_ready_1;
  logic       resp_valid_0, resp_valid_1;
  logic [3:0] resp_result;
  logic [3:0] resp_flags;
  logic       busy;
  logic [7:0] op_count;

  int total = 0;
  int bad   = 0;

  alu_arbiter #(.WIDTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid_0  (v[0]),
    .req_valid_1  (v[1]),
    .req_ready_0  (req_ready_0),
    .req_ready_1  (req_ready_1),
    .req_a_0      (a[0]),
    .req_b_0      (b[0]),
    .req_a_1      (a[1]),
    .req_b_1      (b[1]),
    .req_op_0     (op[0]),
    .req_op_1     (op[1]),
    .resp_valid_0 (resp_valid_0),
    .resp_valid_1 (resp_valid_1),
    .resp_ready_0 (rr[0]),
    .resp_ready_1 (rr[1]),
    .resp_result  (resp_result),
    .resp_flags   (resp_flags),
    .busy         (busy),
    .op_count     (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one optional in-flight job with an age in cycles since
  // acceptance; the response is visible from age 1 until consumed.
  bit         checks_on = 0;
  bit         m_pend = 0;
  int         m_own  = 0;
  int         m_age  = 0;
  int         m_prio = 0;
  int         m_cnt  = 0;
  int         m_acc  = -1;
  logic [3:0] p_res, p_flg;
  logic [3:0] m_res = 4'd0;
  logic [3:0] m_flg = 4'd0;
  int         gq[$];

  function automatic void alu_ref(input int ai, input int bi, input int opi,
                                  output logic [3:0] r, output logic [3:0] f);
    int raw, sa, sb, sr;
    bit c, ov;
    sa = (ai > 7) ? ai - 16 : ai;
    sb = (bi > 7) ? bi - 16 : bi;
    c = 0; ov = 0; raw = 0;
    case (opi)
      0: raw = ai & bi;
      1: raw = ai | bi;
      2: begin raw = ai + bi; c = (raw > 15); sr = sa + sb; ov = (sr > 7) || (sr < -8); end
      default: begin raw = ai - bi; c = (ai >= bi); sr = sa - sb; ov = (sr > 7) || (sr < -8); end
    endcase
    r = 4'(raw & 15);
    f = {r[3], (r == 4'd0), c, ov};
  endfunction

  function automatic int exp_grant();
    if (v[0] && v[1]) return m_prio;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", nm, $time, got, exp);
    end
  endtask

  task automatic check_cycle();
    int g;
    bit resp_on;
    if (!checks_on) return;
    g = exp_grant();
    resp_on = m_pend && (m_age >= 1);
    chk("req_ready_0", {7'd0, req_ready_0}, {7'd0, (!rst && !m_pend && g == 0)});
    chk("req_ready_1", {7'd0, req_ready_1}, {7'd0, (!rst && !m_pend && g == 1)});
    chk("resp_valid_0", {7'd0, resp_valid_0}, {7'd0, (resp_on && m_own == 0)});
    chk("resp_valid_1", {7'd0, resp_valid_1}, {7'd0, (resp_on && m_own == 1)});
    chk("busy", {7'd0, busy}, {7'd0, m_pend});
    chk("resp_result", {4'd0, resp_result}, {4'd0, m_res});
    chk("resp_flags", {4'd0, resp_flags}, {4'd0, m_flg});
    chk("op_count", op_count, 8'(m_cnt));
    chk("ready_exclusive", {7'd0, (req_ready_0 && req_ready_1)}, 8'd0);
  endtask

  task automatic model_update();
    int g;
    m_acc = -1;
    g = exp_grant();
    if (rst) begin
      m_pend = 0; m_prio = 0; m_cnt = 0; m_res = 4'd0; m_flg = 4'd0;
    end else if (!m_pend) begin
      if (g >= 0) begin
        m_pend = 1; m_own = g; m_age = 0; m_acc = g;
        alu_ref(int'(a[g]), int'(b[g]), int'(op[g]), p_res, p_flg);
      end
    end else if (m_age == 0) begin
      m_age = 1; m_res = p_res; m_flg = p_flg;
    end else if (rr[m_own]) begin
      m_pend = 0; m_cnt = (m_cnt + 1) % 256; m_prio = 1 - m_own;
    end
  endtask

  // Inputs are driven at the negedge; outputs compared 1 time unit later.
  task automatic tick();
    #1;
    check_cycle();
    if (req_ready_0) gq.push_back(0);
    else if (req_ready_1) gq.push_back(1);
    @(posedge clk);
    model_update();
    checks_on = 1;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    v[0] = 0; v[1] = 0; rr[0] = 1; rr[1] = 1;
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic do_op(input int c, input logic [3:0] ai, input logic [3:0] bi,
                       input logic [1:0] opi, input logic [3:0] er,
                       input logic [3:0] ef, input string nm);
    idle_inputs();
    v[c] = 1; a[c] = ai; b[c] = bi; op[c] = opi;
    tick();
    v[c] = 0; a[c] = 4'($urandom); b[c] = 4'($urandom); op[c] = 2'($urandom);
    tick();
    #1;
    chk({nm, "_valid"}, {7'd0, (c == 0) ? resp_valid_0 : resp_valid_1}, 8'd1);
    chk({nm, "_result"}, {4'd0, resp_result}, {4'd0, er});
    chk({nm, "_flags"}, {4'd0, resp_flags}, {4'd0, ef});
    tick();
  endtask

  bit c_pend[2];

  initial begin
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1; rr[i] = 1; a[i] = 4'd3; b[i] = 4'd5; op[i] = 2'd2;
    end
    @(negedge clk);

    // Reset for two cycles with both clients requesting
    tick();
    tick();
    rst = 0;
    #1;
    chk("post_reset_ready_0", {7'd0, req_ready_0}, 8'd1);
    chk("post_reset_ready_1", {7'd0, req_ready_1}, 8'd0);
    chk("post_reset_count", op_count, 8'd0);
    chk("post_reset_result", {4'd0, resp_result}, 8'd0);

    // Contention: both clients valid continuously, responses consumed at once
    gq.delete();
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 2; k++) begin
        a[k] = 4'($urandom); b[k] = 4'($urandom); op[k] = 2'($urandom);
      end
      tick();
    end
    chk("grant_count", 8'(gq.size() >= 4), 8'd1);
    if (gq.size() >= 4) begin
      chk("grant_seq0", 8'(gq[0]), 8'd0);
      chk("grant_seq1", 8'(gq[1]), 8'd1);
      chk("grant_seq2", 8'(gq[2]), 8'd0);
      chk("grant_seq3", 8'(gq[3]), 8'd1);
    end

    // Directed operations with hand-computed results
    idle_inputs();
    do_reset();
    do_op(0, 4'b1110, 4'b1110, 2'b10, 4'b1100, 4'b1010, "add");
    #1;
    chk("add_count", op_count, 8'd1);
    do_op(1, 4'b1111, 4'b0111, 2'b11, 4'b1000, 4'b1010, "sub");
    do_op(0, 4'b0111, 4'b0010, 2'b00, 4'b0010, 4'b0000, "and1");
    do_op(1, 4'b0101, 4'b1010, 2'b00, 4'b0000, 4'b0100, "and0");
    do_op(0, 4'b1111, 4'b1111, 2'b01, 4'b1111, 4'b1000, "or");
    do_op(1, 4'b0111, 4'b0001, 2'b10, 4'b1000, 4'b1001, "add_ovf");
    do_op(0, 4'b0010, 4'b0101, 2'b11, 4'b1101, 4'b1000, "sub_borrow");

    // Response stall on client 0 while client 1 waits
    do_reset();
    v[0] = 1; v[1] = 1; rr[0] = 0; rr[1] = 1;
    a[0] = 4'd9; b[0] = 4'd4; op[0] = 2'b11;
    a[1] = 4'd2; b[1] = 4'd3; op[1] = 2'b10;
    tick();
    v[0] = 0;
    tick();
    for (int i = 0; i < 10; i++) tick();
    #1;
    chk("stall_ready_1", {7'd0, req_ready_1}, 8'd0);
    chk("stall_valid_0", {7'd0, resp_valid_0}, 8'd1);
    chk("stall_result", {4'd0, resp_result}, 8'd5);
    rr[0] = 1;
    tick();
    #1;
    chk("after_stall_ready_1", {7'd0, req_ready_1}, 8'd1);
    tick();
    v[1] = 0;
    tick(); tick(); tick();

    // Reset while the operation is executing
    idle_inputs();
    v[0] = 1; a[0] = 4'd7; b[0] = 4'd7; op[0] = 2'b10;
    tick();
    v[0] = 0; rst = 1;
    tick();
    rst = 0;
    #1;
    chk("midrst_busy", {7'd0, busy}, 8'd0);
    chk("midrst_valid", {7'd0, resp_valid_0}, 8'd0);
    chk("midrst_result", {4'd0, resp_result}, 8'd0);
    chk("midrst_count", op_count, 8'd0);
    for (int i = 0; i < 4; i++) tick();

    // Counter wrap after 256 completions
    do_reset();
    for (int n = 0; n < 256; n++) begin
      v[0] = 1; a[0] = 4'($urandom); b[0] = 4'($urandom); op[0] = 2'($urandom);
      tick();
      v[0] = 0;
      tick();
      tick();
    end
    #1;
    chk("wrap_count", op_count, 8'd0);

    // Randomized traffic; each client holds a request until it is accepted
    do_reset();
    c_pend[0] = 0; c_pend[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 2; k++) begin
        if (!c_pend[k] && $urandom_range(0, 1) == 1) begin
          c_pend[k] = 1;
          a[k] = 4'($urandom); b[k] = 4'($urandom); op[k] = 2'($urandom);
        end else if (!c_pend[k]) begin
          a[k] = 4'($urandom); b[k] = 4'($urandom); op[k] = 2'($urandom);
        end
        v[k] = c_pend[k];
        rr[k] = ($urandom_range(0, 3) != 0);
      end
      rst = ($urandom_range(0, 499) == 0);
      tick();
      if (m_acc >= 0) c_pend[m_acc] = 0;
      if (rst) begin
        rst = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
